mux8_rr_arbiter: RTL

Round-robin arbiter that shares one 8:1 word selector between eight requesters. It also drives a single registered output stream with valid/ready flow control. Each requester is granted bursts of up to MAX_BURST words before the grant rotates. The block sits between the per-channel sources and the downstream consumer, and owns the 3-bit select that steers the 8:1 datapath.

---
 rtl/mux8_rr_arbiter_if.sv | 35 +++
 rtl/mux8_rr_arbiter.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// mux8_rr_arbiter_if: requester/consumer bundle for the 8-way round-robin arbiter.
// The lock signal exists only when MUX_ARB_LOCK_EN is defined.
interface mux8_rr_arbiter_if #(
   parameter int DW = 8
) ();
   logic [7:0]      req;
   logic [8*DW-1:0] in_data;
   logic [7:0]      ack;
   logic [2:0]      sel;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic [2:0]      out_id;
`ifdef MUX_ARB_LOCK_EN
   logic            lock;

   modport master (
      input  req, in_data, out_ready, lock,
      output ack, sel, out_valid, out_data, out_id
   );
   modport slave (
      output req, in_data, out_ready, lock,
      input  ack, sel, out_valid, out_data, out_id
   );
`else
   modport master (
      input  req, in_data, out_ready,
      output ack, sel, out_valid, out_data, out_id
   );
   modport slave (
      output req, in_data, out_ready,
      input  ack, sel, out_valid, out_data, out_id
   );
`endif
endinterface

// File: rtl/mux8_rr_arbiter.sv
// mux8_rr_arbiter: round-robin arbiter over eight requesters with bursts of
// up to MAX_BURST words, feeding one registered valid/ready output stage.
// Optional feature: define MUX_ARB_LOCK_EN to add the burst lock input.
module mux8_rr_arbiter #(
   parameter int DW        = 8,
   parameter int MAX_BURST = 4
) (
   input logic               clk,
   input logic               rst,
   mux8_rr_arbiter_if.master bus
);

   typedef enum logic {IDLE, BURST} state_t;

   localparam logic [3:0] MAXB = 4'(MAX_BURST);

   state_t          state, state_nx;
   logic [2:0]      ptr, ptr_nx;
   logic [2:0]      owner, owner_nx;
   logic [3:0]      cnt, cnt_nx;
   logic            out_valid_q, out_valid_nx;
   logic [DW-1:0]   out_data_q, out_data_nx;
   logic [2:0]      out_id_q, out_id_nx;

   logic            lock_on;
   logic            space;
   logic            keep;
   logic            found;
   logic [2:0]      cand;
   logic [DW-1:0]   cand_word;
   logic            ld;

`ifdef MUX_ARB_LOCK_EN
   assign lock_on = bus.lock;
`else
   assign lock_on = 1'b0;
`endif

   // The output register can take a word when empty or being drained this cycle.
   assign space = !out_valid_q || bus.out_ready;

   // Candidate: the burst owner while it may continue, else first request after ptr.
   always_comb begin
      logic [2:0] idx;
      idx   = '0;
      found = 1'b0;
      cand  = owner;
      keep  = (state == BURST) && bus.req[owner] && ((cnt < MAXB) || lock_on);
      if (keep) begin
         found = 1'b1;
      end else begin
         // k = 8 wraps to ptr itself, so the previous owner is searched last.
         for (int k = 1; k <= 8; k++) begin
            idx = ptr + 3'(k);
            if (!found && bus.req[idx]) begin
               found = 1'b1;
               cand  = idx;
            end
         end
      end
   end

   assign cand_word = bus.in_data[cand*DW +: DW];
   assign ld        = space && found;

   // ack is forced low during reset even though the output stage looks empty.
   assign bus.ack       = (ld && !rst) ? (8'b1 << cand) : 8'b0;
   assign bus.sel       = owner;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_id    = out_id_q;

   // Next-state and load decisions; everything holds while backpressured.
   always_comb begin
      state_nx     = state;
      ptr_nx       = ptr;
      owner_nx     = owner;
      cnt_nx       = cnt;
      out_valid_nx = out_valid_q;
      out_data_nx  = out_data_q;
      out_id_nx    = out_id_q;
      if (ld) begin
         out_valid_nx = 1'b1;
         out_data_nx  = cand_word;
         out_id_nx    = cand;
         if (keep) begin
            // Locked bursts can run past MAX_BURST; the count stays pinned.
            cnt_nx = (cnt < MAXB) ? cnt + 4'd1 : cnt;
         end else begin
            owner_nx = cand;
            ptr_nx   = cand;
            cnt_nx   = 4'd1;
            state_nx = BURST;
         end
      end else if (space) begin
         // No requester at all: the output drains and the burst ends.
         out_valid_nx = 1'b0;
         state_nx     = IDLE;
      end
   end

   // State, arbitration and output registers; reset clears the burst at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         ptr         <= 3'd7;
         owner       <= 3'd0;
         cnt         <= 4'd0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_id_q    <= 3'd0;
      end else begin
         state       <= state_nx;
         ptr         <= ptr_nx;
         owner       <= owner_nx;
         cnt         <= cnt_nx;
         out_valid_q <= out_valid_nx;
         out_data_q  <= out_data_nx;
         out_id_q    <= out_id_nx;
      end
   end

endmodule
